// File: rtl/ram_word_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ram_word_streamer -- streams a programmable run of words from a fixed-latency block RAM
// onto a valid/ready port with full backpressure.  Rev 1.0
module ram_word_streamer #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 1,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic [DATA_W-1:0] q,
   output logic [ADDR_W-1:0] read_addr,
   output logic              read_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              busy,
   output logic              done
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int c_SUM_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr_cnt;
   logic [ADDR_W:0]     r_remaining;
   logic [RD_LAT-1:0]   r_sr;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_push;
   logic                w_pop;
   logic                w_issue;
   logic                w_drain_done;
   logic [c_SUM_W-1:0]  w_inflight;
   logic [c_SUM_W-1:0]  w_used;

   assign data_out   = r_mem[r_rd_ptr];
   assign data_valid = (r_count != '0);
   assign w_pop      = data_valid && data_ready;
   assign w_push     = r_sr[RD_LAT-1];

   // Outstanding reads: the registered read_en stage plus every tag still in the latency pipe.
   always_comb begin
      w_inflight = c_SUM_W'(read_en);
      for (int i = 0; i < RD_LAT; i++) begin
         w_inflight = w_inflight + c_SUM_W'(r_sr[i]);
      end
   end

   // A word leaving the FIFO this cycle frees its slot in time for a new issue, which is
   // what sustains one word per cycle; occupancy still never exceeds FIFO_DEPTH.
   assign w_used       = c_SUM_W'(r_count) + w_inflight - c_SUM_W'(w_pop);
   assign w_issue      = (r_state == S_RUN) && (r_remaining != '0) &&
                         (w_used < c_SUM_W'(FIFO_DEPTH));
   assign w_drain_done = (w_inflight == '0) &&
                         ((r_count == '0) || ((r_count == c_CNT_W'(1)) && w_pop));

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_addr_cnt  <= '0;
         r_remaining <= '0;
         read_addr   <= '0;
         read_en     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         read_en <= w_issue;
         done    <= 1'b0;
         if (w_issue) begin
            read_addr   <= r_addr_cnt;
            r_addr_cnt  <= r_addr_cnt + 1'b1;
            r_remaining <= r_remaining - 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (start && !done) begin
                  r_addr_cnt  <= base_addr;
                  r_remaining <= length;
                  busy        <= 1'b1;
                  r_state     <= (length == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (w_issue && (r_remaining == (ADDR_W+1)'(1))) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_drain_done) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_sr     <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_sr[0] <= read_en;
         for (int i = 1; i < RD_LAT; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
         if (w_push) begin
            r_mem[r_wr_ptr] <= q;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n)
      !(w_push && !w_pop && (r_count == c_CNT_W'(FIFO_DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_ram_word_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ram_word_streamer -- randomized bench; expected words come from the RAM image by address.
// Rev 1.0
module tb_ram_word_streamer;

   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 8;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int LEN_W      = ADDR_W + 1;
   localparam int NWORDS     = 1 << ADDR_W;

   logic              clk_in = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  length = '0;
   logic [DATA_W-1:0] q = '0;
   logic              data_ready = 1'b0;
   logic [ADDR_W-1:0] read_addr;
   logic              read_en;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              busy;
   logic              done;

   ram_word_streamer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .length(length), .q(q), .read_addr(read_addr), .read_en(read_en),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .busy(busy), .done(done)
   );

   always #5 clk_in = ~clk_in;

   // Block RAM: address/enable captured one edge after read_en, data one edge later.
   logic [DATA_W-1:0] mem [NWORDS];
   logic              p_en = 1'b0;
   logic [ADDR_W-1:0] p_addr = '0;
   always @(posedge clk_in) begin
      p_en   <= read_en;
      p_addr <= read_addr;
      q      <= p_en ? mem[p_addr] : DATA_W'($urandom);
   end

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   int start_edge = 0;

   // Event logs recorded on the falling edge, away from the active edge.
   logic [ADDR_W-1:0] rd_q [$];
   logic [DATA_W-1:0] acc_q [$];
   int                acc_cyc [$];
   int busy_cyc, done_cnt, done_cyc, first_valid_cyc, stall_viol, max_out;
   logic              prev_hold = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;

   always @(negedge clk_in) begin
      int outs;
      if (read_en) rd_q.push_back(read_addr);
      outs = rd_q.size() - acc_q.size();
      if (outs > max_out) max_out = outs;
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (data_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_hold && data_valid && data_out !== prev_data) stall_viol++;
      prev_hold = data_valid && !data_ready;
      prev_data = data_out;
      if (data_valid && data_ready) begin
         acc_q.push_back(data_out);
         acc_cyc.push_back(cyc);
      end
   end

   task automatic clear_logs();
      rd_q.delete(); acc_q.delete(); acc_cyc.delete();
      busy_cyc = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
      stall_viol = 0; max_out = 0; prev_hold = 1'b0;
   endtask

   function automatic int seq_mismatch(input int base, input int len, output int first_bad);
      int bad;
      bad = 0;
      first_bad = -1;
      if (acc_q.size() != len) begin bad++; first_bad = acc_q.size(); end
      for (int i = 0; i < len && i < acc_q.size(); i++) begin
         if (acc_q[i] !== mem[(base + i) % NWORDS]) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      return bad;
   endfunction

   function automatic int addr_mismatch(input int base, input int len);
      int bad;
      bad = (rd_q.size() != len) ? 1 : 0;
      for (int i = 0; i < len && i < rd_q.size(); i++) begin
         if (int'(rd_q[i]) != ((base + i) % NWORDS)) bad++;
      end
      return bad;
   endfunction

   // rmode: 0 ready held high, 1 random ready, 2 fixed backpressure pattern after first valid.
   task automatic do_run(input int base, input int len, input int rmode, input int restart_at,
                         input bit start_on_done, output bit timed_out);
      logic [13:0] pat;
      int          pat_i;
      bit          seen_valid;
      pat        = 14'b10010000000000;
      pat_i      = 0;
      seen_valid = 1'b0;
      clear_logs();
      base_addr  = ADDR_W'(base);
      length     = LEN_W'(len);
      start      = 1'b1;
      start_edge = cyc + 1;
      data_ready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      timed_out  = 1'b1;
      for (int k = 0; k < len * 6 + 64; k++) begin
         @(posedge clk_in); #1;
         start = 1'b0;
         if (k == restart_at) begin
            start     = 1'b1;
            base_addr = ~base_addr;
            length    = LEN_W'(9);
         end
         if (rmode == 1) begin
            data_ready = ($urandom_range(0, 3) != 0);
         end else if (rmode == 2) begin
            if (data_valid) seen_valid = 1'b1;
            if (seen_valid && pat_i < 14) begin
               data_ready = pat[13 - pat_i];
               pat_i++;
            end else begin
               data_ready = 1'b1;
            end
         end else begin
            data_ready = 1'b1;
         end
         if (done) begin
            timed_out = 1'b0;
            if (start_on_done) begin
               start     = 1'b1;
               base_addr = ADDR_W'($urandom);
               length    = LEN_W'(5);
            end
            break;
         end
      end
      repeat (4) begin
         @(posedge clk_in); #1;
         start      = 1'b0;
         data_ready = 1'b1;
      end
   endtask

   task automatic test_reset();
      start = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if ({read_en, busy, done, data_valid} !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b, want 0000", {read_en, busy, done, data_valid});
      end
      vectors++;
      if (read_addr !== '0) begin
         miscompares++; $display("FAIL reset_addr: got %h, want 000", read_addr);
      end
      vectors++;
      if (data_out !== '0) begin
         miscompares++; $display("FAIL reset_data: got %h, want 00", data_out);
      end
      repeat (3) @(posedge clk_in);
      #1;
      vectors++;
      if ({read_en, busy, done, data_valid} !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_hold: got %b, want 0000", {read_en, busy, done, data_valid});
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk_in); #1;
   endtask

   task automatic test_basic();
      bit to;
      int bad, fb, last;
      do_run(16, 8, 0, -1, 1'b0, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL basic_timeout: no done seen"); end
      bad = seq_mismatch(16, 8, fb);
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL basic_seq: %0d bad (first %0d), got %0d words, want 8", bad, fb, acc_q.size());
      end
      vectors++;
      if (first_valid_cyc != start_edge + RD_LAT + 2) begin
         miscompares++;
         $display("FAIL basic_latency: first valid %0d cycles after start, want %0d",
                  first_valid_cyc - start_edge, RD_LAT + 2);
      end
      last = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] : -100;
      vectors++;
      if (acc_cyc.size() != 8 || last - acc_cyc[0] != 7) begin
         miscompares++;
         $display("FAIL basic_rate: got %0d words over span %0d, want 8 over 7", acc_cyc.size(),
                  last - ((acc_cyc.size() > 0) ? acc_cyc[0] : 0));
      end
      // Last handshake lands on edge last+1 (enter DONE); done shows after the next edge.
      vectors++;
      if (done_cnt != 1 || done_cyc != last + 2) begin
         miscompares++;
         $display("FAIL basic_done: got %0d pulses at offset %0d, want 1 at offset 2",
                  done_cnt, done_cyc - last);
      end
   endtask

   task automatic test_wrap();
      bit to;
      int bad, fb;
      do_run('hFFE, 4, 0, -1, 1'b0, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL wrap_timeout: no done seen"); end
      vectors++;
      if (addr_mismatch('hFFE, 4) != 0) begin
         miscompares++;
         $display("FAIL wrap_addr: got %0d reads starting %h, want FFE FFF 000 001", rd_q.size(),
                  (rd_q.size() > 0) ? rd_q[0] : 12'h0);
      end
      bad = seq_mismatch('hFFE, 4, fb);
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL wrap_seq: %0d bad (first %0d), want 0", bad, fb);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int bad, fb, b;
      b = int'($urandom_range(0, NWORDS - 1));
      do_run(b, 32, 2, -1, 1'b0, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL bp_timeout: no done seen"); end
      bad = seq_mismatch(b, 32, fb);
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL bp_seq: %0d bad (first %0d), got %0d words, want 32", bad, fb, acc_q.size());
      end
      vectors++;
      if (stall_viol != 0) begin
         miscompares++; $display("FAIL bp_stable: data_out changed %0d times while stalled, want 0", stall_viol);
      end
      vectors++;
      if (max_out != FIFO_DEPTH) begin
         miscompares++; $display("FAIL bp_credit: peak outstanding %0d, want %0d", max_out, FIFO_DEPTH);
      end
   endtask

   task automatic test_zero_len();
      bit to;
      do_run(int'($urandom_range(0, NWORDS - 1)), 0, 0, -1, 1'b0, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL zero_timeout: no done seen"); end
      vectors++;
      if (rd_q.size() != 0) begin
         miscompares++; $display("FAIL zero_reads: got %0d read_en cycles, want 0", rd_q.size());
      end
      vectors++;
      if (busy_cyc != 1) begin
         miscompares++; $display("FAIL zero_busy: busy high %0d cycles, want 1", busy_cyc);
      end
      vectors++;
      if (done_cnt != 1 || done_cyc != start_edge + 1) begin
         miscompares++;
         $display("FAIL zero_done: got %0d pulses at +%0d, want 1 at +1", done_cnt, done_cyc - start_edge);
      end
   endtask

   task automatic test_ignored_start();
      bit to;
      int bad, fb, b;
      b = int'($urandom_range(0, NWORDS - 1));
      do_run(b, 6, 0, 2, 1'b1, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL ign_timeout: no done seen"); end
      bad = seq_mismatch(b, 6, fb);
      vectors++;
      if (bad != 0 || rd_q.size() != 6) begin
         miscompares++;
         $display("FAIL ign_seq: %0d bad words, %0d reads, want 0 bad and 6 reads", bad, rd_q.size());
      end
      vectors++;
      if (busy !== 1'b0 || done_cnt != 1) begin
         miscompares++;
         $display("FAIL ign_idle: busy=%b done pulses=%0d, want busy=0 and 1 pulse", busy, done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int bad, fb, b1, b2;
      b1 = int'($urandom_range(0, NWORDS - 1));
      b2 = int'($urandom_range(0, NWORDS - 1));
      clear_logs();
      data_ready = 1'b1;
      base_addr  = ADDR_W'(b1);
      length     = LEN_W'(16);
      start      = 1'b1;
      for (int k = 0; k < 64 && acc_q.size() < 5; k++) begin
         @(posedge clk_in); #1;
         start = 1'b0;
      end
      vectors++;
      if (acc_q.size() != 5) begin
         miscompares++; $display("FAIL rstmid_reach: got %0d words before reset, want 5", acc_q.size());
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({read_en, busy, done, data_valid, read_addr, data_out} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_async: en=%b busy=%b done=%b valid=%b addr=%h data=%h, want all 0",
                  read_en, busy, done, data_valid, read_addr, data_out);
      end
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      vectors++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_nodone: got %0d done pulses busy=%b, want 0 and 0", done_cnt, busy);
      end
      rst_n = 1'b1;
      @(posedge clk_in); #1;
      do_run(b2, 16, 0, -1, 1'b0, to);
      bad = seq_mismatch(b2, 16, fb);
      vectors++;
      if (to || bad != 0 || done_cnt != 1) begin
         miscompares++;
         $display("FAIL rstmid_rerun: timeout=%0d bad=%0d done=%0d, want 0 0 1", to, bad, done_cnt);
      end
   endtask

   task automatic test_random();
      bit to;
      int bad, fb, b, n;
      for (int r = 0; r < 5; r++) begin
         b = int'($urandom_range(0, NWORDS - 1));
         n = int'($urandom_range(1, 40));
         do_run(b, n, 1, -1, 1'b0, to);
         bad = seq_mismatch(b, n, fb);
         vectors++;
         if (to || bad != 0) begin
            miscompares++;
            $display("FAIL rand%0d_seq: timeout=%0d bad=%0d (first %0d), len %0d", r, to, bad, fb, n);
         end
         vectors++;
         if (done_cnt != 1 || stall_viol != 0) begin
            miscompares++;
            $display("FAIL rand%0d_ctl: done=%0d unstable=%0d, want 1 and 0", r, done_cnt, stall_viol);
         end
         vectors++;
         if (max_out > FIFO_DEPTH) begin
            miscompares++; $display("FAIL rand%0d_credit: peak outstanding %0d, want <= %0d", r, max_out, FIFO_DEPTH);
         end
      end
   endtask

   task automatic test_full_ram();
      bit to;
      int bad, fb;
      do_run(0, NWORDS, 0, -1, 1'b0, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL full_timeout: no done seen"); end
      bad = seq_mismatch(0, NWORDS, fb);
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL full_seq: %0d bad (first %0d), got %0d words, want %0d", bad, fb, acc_q.size(), NWORDS);
      end
      vectors++;
      if (addr_mismatch(0, NWORDS) != 0) begin
         miscompares++; $display("FAIL full_addr: got %0d reads, want %0d in order", rd_q.size(), NWORDS);
      end
      vectors++;
      if (done_cnt != 1 || acc_cyc.size() != NWORDS ||
          acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != NWORDS - 1) begin
         miscompares++;
         $display("FAIL full_rate: done=%0d words=%0d, want 1 pulse and %0d back-to-back words",
                  done_cnt, acc_cyc.size(), NWORDS);
      end
   endtask

   initial begin
      for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'(i);
      clear_logs();
      test_reset();
      test_basic();
      for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'($urandom);
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_ignored_start();
      test_reset_mid();
      test_random();
      test_full_ram();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
